// File: rtl/regfile_sb.sv
// Two-read/one-write CPU register file with hardwired zero, write bypass,
// per-register busy scoreboard and a reset sweep that zeroes every entry.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] busw,
  input  logic              regwr,
  input  logic              regdst,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              ready
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   waddr;
  logic                wen;
  logic                res_en;
  logic                init_wr;
  logic                hit_a;
  logic                hit_b;
  logic                zero_a;
  logic                zero_b;

  assign ready  = (state_q == ST_RUN);
  assign waddr  = regdst ? rd : rt;
  assign wen    = regwr & ready & ~(ZERO_REG & (waddr == '0));
  assign res_en = reserve_en & ready & ~(ZERO_REG & (reserve_addr == '0));

  // Sweep sequencing: one zero write per cycle, RUN after the last address.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_wr = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        ptr_d   = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Reserve is applied after the clear so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (wen) begin
      busy_d[waddr] = 1'b0;
    end
    if (res_en) begin
      busy_d[reserve_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset of its own; the sweep clears it after rst drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_wr) begin
        mem_q[ptr_q] <= '0;
      end else if (wen) begin
        mem_q[waddr] <= busw;
      end
    end
  end

  assign zero_a = ZERO_REG & (rs == '0);
  assign zero_b = ZERO_REG & (rt == '0);
  assign hit_a  = BYPASS & wen & (waddr == rs);
  assign hit_b  = BYPASS & wen & (waddr == rt);

  always_comb begin
    busA = '0;
    busB = '0;
    if (ready && !zero_a) begin
      busA = hit_a ? busw : mem_q[rs];
    end
    if (ready && !zero_b) begin
      busB = hit_b ? busw : mem_q[rt];
    end
  end

  assign rs_busy = ready & busy_q[rs] & ~hit_a & ~zero_a;
  assign rt_busy = ready & busy_q[rt] & ~hit_b & ~zero_b;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a bypassing and a non-bypassing instance
// share stimulus; expectations are queued at drive time and checked later.
module tb_regfile_sb;

  localparam int S_A     = 0;
  localparam int S_B     = 1;
  localparam int S_RSB   = 2;
  localparam int S_RTB   = 3;
  localparam int S_RDY   = 4;
  localparam int S_NBA   = 5;
  localparam int S_NBB   = 6;
  localparam int S_NBRSB = 7;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, rd, reserve_addr;
  logic [31:0] busw;
  logic        regwr, regdst, reserve_en;
  logic [31:0] busA, busB, nb_busA, nb_busB;
  logic        rs_busy, rt_busy, ready;
  logic        nb_rs_busy, nb_rt_busy, nb_ready;

  exp_t        exp_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_ready;
  logic        m_valid = 1'b0;
  int          m_cnt;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .busw(busw),
    .regwr(regwr), .regdst(regdst), .reserve_en(reserve_en),
    .reserve_addr(reserve_addr), .busA(busA), .busB(busB),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .ready(ready)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .busw(busw),
    .regwr(regwr), .regdst(regdst), .reserve_en(reserve_en),
    .reserve_addr(reserve_addr), .busA(nb_busA), .busB(nb_busB),
    .rs_busy(nb_rs_busy), .rt_busy(nb_rt_busy), .ready(nb_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_A:     return busA;
      S_B:     return busB;
      S_RSB:   return 32'(rs_busy);
      S_RTB:   return 32'(rt_busy);
      S_RDY:   return 32'(ready);
      S_NBA:   return nb_busA;
      S_NBB:   return nb_busB;
      S_NBRSB: return 32'(nb_rs_busy);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic exp_push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Expected outputs for the current inputs from the reference model.
  task automatic push_model();
    logic [4:0]  wa;
    logic        we_m;
    logic [31:0] a, b, a_nb, b_nb;
    logic        rsb, rtb, rsb_nb;
    if (!m_valid) return;
    wa   = regdst ? rd : rt;
    we_m = regwr && m_ready && (wa != 5'd0);
    a    = 32'h0;
    b    = 32'h0;
    a_nb = 32'h0;
    b_nb = 32'h0;
    if (m_ready && rs != 5'd0) begin
      a    = (we_m && wa == rs) ? busw : m_mem[rs];
      a_nb = m_mem[rs];
    end
    if (m_ready && rt != 5'd0) begin
      b    = (we_m && wa == rt) ? busw : m_mem[rt];
      b_nb = m_mem[rt];
    end
    rsb    = m_ready && rs != 5'd0 && m_busy[rs] && !(we_m && wa == rs);
    rtb    = m_ready && rt != 5'd0 && m_busy[rt] && !(we_m && wa == rt);
    rsb_nb = m_ready && rs != 5'd0 && m_busy[rs];
    exp_push("m_busA", S_A, a);
    exp_push("m_busB", S_B, b);
    exp_push("m_rs_busy", S_RSB, 32'(rsb));
    exp_push("m_rt_busy", S_RTB, 32'(rtb));
    exp_push("m_ready", S_RDY, 32'(m_ready));
    exp_push("m_nb_busA", S_NBA, a_nb);
    exp_push("m_nb_busB", S_NBB, b_nb);
    exp_push("m_nb_rs_busy", S_NBRSB, 32'(rsb_nb));
  endtask

  task automatic drive(input logic r, input logic we, input logic dst,
                       input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rd,
                       input logic [31:0] w, input logic res, input logic [4:0] ra);
    @(negedge clk);
    rst          = r;
    regwr        = we;
    regdst       = dst;
    rs           = a_rs;
    rt           = a_rt;
    rd           = a_rd;
    busw         = w;
    reserve_en   = res;
    reserve_addr = ra;
    push_model();
  endtask

  // Compare everything queued for this cycle, then advance the model past the edge.
  task automatic settle();
    exp_t        e;
    logic [4:0]  wa;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_cnt   = 0;
      m_busy  = 32'h0;
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    end else if (m_valid) begin
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == 32) m_ready = 1'b1;
      end else begin
        wa = regdst ? rd : rt;
        if (regwr && wa != 5'd0) begin
          m_mem[wa]  = busw;
          m_busy[wa] = 1'b0;
        end
        if (reserve_en && reserve_addr != 5'd0) m_busy[reserve_addr] = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic [4:0] a_rs, input logic [4:0] a_rt);
    drive(1'b0, 1'b0, 1'b0, a_rs, a_rt, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; regwr = 1'b0; regdst = 1'b0; reserve_en = 1'b0;
    rs = '0; rt = '0; rd = '0; reserve_addr = '0; busw = '0;

    // Reset sweep; writes and reserves during INIT must be dropped.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd9, 5'd5, 32'h1111_1111, 1'b1, 5'd9);
      exp_push("init_ready_low", S_RDY, 32'h0);
      exp_push("init_busA_zero", S_A, 32'h0);
      settle();
    end
    idle(5'd5, 5'd9);
    exp_push("ready_after_32", S_RDY, 32'h1);
    exp_push("init_write_ignored", S_A, 32'h0);
    exp_push("init_reserve_ignored", S_RTB, 32'h0);
    settle();
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      exp_push("sweep_zero_A", S_A, 32'h0);
      exp_push("sweep_zero_B", S_B, 32'h0);
      settle();
    end

    // Destination select.
    drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    settle();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd7, 5'd5, 32'h1234_5678, 1'b0, 5'd0);
    settle();
    idle(5'd5, 5'd7);
    exp_push("regdst1_rd5", S_A, 32'hDEAD_BEEF);
    exp_push("regdst0_rt7", S_B, 32'h1234_5678);
    settle();

    // Zero register.
    drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    exp_push("zero_same_cycle", S_A, 32'h0);
    settle();
    idle(5'd0, 5'd0);
    exp_push("zero_after_write", S_A, 32'h0);
    exp_push("zero_after_write_nb", S_NBA, 32'h0);
    settle();

    // Bypass versus no bypass.
    drive(1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0);
    exp_push("bypass_A", S_A, 32'hA5A5_A5A5);
    exp_push("bypass_B", S_B, 32'hA5A5_A5A5);
    exp_push("nobypass_old", S_NBA, 32'h0);
    settle();
    idle(5'd3, 5'd0);
    exp_push("nobypass_next", S_NBA, 32'hA5A5_A5A5);
    settle();

    // Scoreboard.
    drive(1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0, 1'b1, 5'd9);
    exp_push("reserve_not_yet", S_RSB, 32'h0);
    settle();
    idle(5'd9, 5'd0);
    exp_push("reserve_busy", S_RSB, 32'h1);
    settle();
    drive(1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0, 1'b1, 5'd9);
    exp_push("rereserve_busy", S_RSB, 32'h1);
    settle();
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 32'h0000_0099, 1'b0, 5'd0);
    exp_push("write_drops_busy", S_RSB, 32'h0);
    exp_push("nb_write_keeps_busy", S_NBRSB, 32'h1);
    exp_push("write_bypass_9", S_A, 32'h0000_0099);
    settle();
    idle(5'd9, 5'd0);
    exp_push("busy_cleared", S_RSB, 32'h0);
    exp_push("nb_busy_cleared", S_NBRSB, 32'h0);
    settle();
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 32'h0000_0999, 1'b1, 5'd9);
    exp_push("wr_res_same_cycle", S_RSB, 32'h0);
    settle();
    idle(5'd9, 5'd0);
    exp_push("reserve_wins", S_RSB, 32'h1);
    settle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 5'd0);
    settle();
    idle(5'd0, 5'd0);
    exp_push("reserve_reg0_ignored", S_RSB, 32'h0);
    settle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd12, 5'd0, 32'h0, 1'b1, 5'd12);
    settle();
    idle(5'd0, 5'd12);
    exp_push("rt_busy_set", S_RTB, 32'h1);
    settle();

    // Reset in the middle of a sweep restarts it and clears busy bits.
    drive(1'b1, 1'b0, 1'b0, 5'd9, 5'd5, 5'd0, 32'h0, 1'b0, 5'd0);
    settle();
    for (int i = 0; i < 10; i++) begin
      idle(5'd9, 5'd5);
      settle();
    end
    drive(1'b1, 1'b0, 1'b0, 5'd9, 5'd5, 5'd0, 32'h0, 1'b0, 5'd0);
    exp_push("midsweep_ready_low", S_RDY, 32'h0);
    settle();
    for (int i = 0; i < 32; i++) begin
      idle(5'd9, 5'd5);
      exp_push("resweep_ready_low", S_RDY, 32'h0);
      settle();
    end
    idle(5'd9, 5'd5);
    exp_push("resweep_ready_high", S_RDY, 32'h1);
    exp_push("resweep_busy9_clear", S_RSB, 32'h0);
    exp_push("resweep_reg5_zero", S_B, 32'h0);
    settle();

    // Random traffic over a narrow address window to force collisions.
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            32'($urandom), 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      settle();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle CPU register file: 2 async read ports, 1 sync write port with rd/rt destination select.
- Adds a hardwired zero register, optional write-to-read bypass, a per-register busy scoreboard for multi-cycle producers, and a reset sweep FSM that clears every register.
- Sits between decode (rs/rt/rd) and writeback (busw) in the datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width. Depth DEPTH = 2**ADDR_W is a derived localparam.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reserves.
- BYPASS, 1, when 1 a same-cycle write is forwarded to busA/busB.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs  in  ADDR_W  read address A.
- rt  in  ADDR_W  read address B; also write destination when regdst=0.
- rd  in  ADDR_W  write destination when regdst=1.
- busw  in  DATA_W  write data.
- regwr  in  1  write enable.
- regdst  in  1  destination select: 1 selects rd, 0 selects rt.
- reserve_en  in  1  mark reserve_addr busy.
- reserve_addr  in  ADDR_W  register to reserve.
- busA  out  DATA_W  read data for rs.
- busB  out  DATA_W  read data for rt.
- rs_busy  out  1  rs has a pending producer.
- rt_busy  out  1  rt has a pending producer.
- ready  out  1  init sweep complete; block accepts writes and reserves.

Behaviour:
- FSM states: INIT, RUN.
- On rst=1 at a clock edge:
  - state goes to INIT, sweep pointer to 0, ready to 0.
  - all busy bits clear.
  - applies from any state, including mid-sweep, where the sweep restarts at 0.
- INIT:
  - each cycle writes 0 to mem[ptr], then ptr increments.
  - the cycle that writes ptr = DEPTH-1 moves state to RUN. INIT lasts exactly DEPTH cycles after rst deasserts.
  - ready = 1 only in RUN.
- While ready = 0:
  - regwr and reserve_en are ignored.
  - busA, busB, rs_busy and rt_busy are driven 0.
- Write path:
  - waddr = regdst ? rd : rt.
  - wen = regwr & ready & !(ZERO_REG & waddr==0).
  - mem[waddr] <= busw on the edge, visible from the next cycle.
- Read paths are combinational. busA priority, highest first:
  1. ZERO_REG & rs==0 gives 0.
  2. BYPASS & wen & waddr==rs gives busw.
  3. Otherwise mem[rs].
- busB follows the same priority with rt.
- With BYPASS = 0, a same-cycle write is not visible until the next cycle.
- Scoreboard (DEPTH bits):
  - reserve_en & ready & !(ZERO_REG & reserve_addr==0) sets busy[reserve_addr].
  - wen clears busy[waddr].
  - reserve and write to the same address in the same cycle: busy ends set (reserve wins; new producer).
  - reserving an already-busy register leaves it busy, with no error.
- rs_busy = busy[rs] & !(BYPASS & wen & waddr==rs); rt_busy is analogous.
  - With ZERO_REG = 1, rs_busy and rt_busy are 0 for address 0.
- Registers 1..DEPTH-1 hold value across RUN except when written. Only rst reinitialises them.

Test Plan:
- Reset sweep: pulse rst for 1 cycle with DEPTH=32. ready stays 0 for 32 cycles, then rises. Every address reads 0. A regwr issued during INIT writes nothing.
- Destination select: write 0xDEADBEEF with regdst=1, rd=5; then 0x12345678 with regdst=0, rt=7. Next cycle rs=5 gives busA=0xDEADBEEF and rt=7 gives busB=0x12345678.
- Zero register and bypass: write 0xFFFFFFFF to reg 0, which then reads 0. Write 0xA5A5A5A5 to reg 3 with rs=3 in the same cycle: busA=0xA5A5A5A5 that cycle. With BYPASS=0, busA shows the old value that cycle.
- Scoreboard: reserve reg 9, so rs=9 gives rs_busy=1. A later write to 9 drops rs_busy combinationally that cycle and leaves it 0 afterwards. Simultaneous reserve+write to 9 leaves rs_busy=1 on the next cycle.
- Mid-sweep reset: assert rst at sweep cycle 10. The sweep restarts, ready rises 32 cycles after the second rst, and the previously busy bit for reg 9 reads 0.
